// File: rtl/multicyc_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// State encoding, datapath select encodings, opcode/funct/rt constants,
// plus two decode helpers: legal R-type funct and branch condition.
package multicyc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWRBCK = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_RREXEC   = 4'd6,
    ST_RRWRBCK  = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JMP      = 4'd9,
    ST_RIEXEC   = 4'd10,
    ST_RIWRBCK  = 4'd11,
    ST_LUI      = 4'd12,
    ST_JMPREG   = 4'd13,
    ST_HALT     = 4'd14
  } state_type;

  typedef enum logic {ADDR_PC = 1'b0, ADDR_ALUOUT = 1'b1} mem_addr_sel_t;
  typedef enum logic {SRCA_PC = 1'b0, SRCA_RS = 1'b1} alu_srca_sel_t;

  typedef enum logic [2:0] {
    SRCB_RT      = 3'd0,
    SRCB_FOUR    = 3'd1,
    SRCB_IMM     = 3'd2,
    SRCB_BEQIMM  = 3'd3,
    SRCB_ZERO    = 3'd4,
    SRCB_ZEROIMM = 3'd5
  } alu_srcb_sel_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_RR   = 4'd8   // ALU decodes funct itself
  } alu_op_t;

  typedef enum logic [1:0] {WR_RT = 2'd0, WR_RD = 2'd1, WR_RA31 = 2'd2} wreg_dst_sel_t;

  typedef enum logic [1:0] {
    WD_ALUOUT  = 2'd0,
    WD_MEMDATA = 2'd1,
    WD_LUI     = 2'd2,
    WD_PCLINK  = 2'd3
  } wreg_data_sel_t;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JMP    = 2'd2,
    NPC_REG    = 2'd3
  } nxt_pc_sel_t;

  // Opcodes
  localparam logic [5:0] OP_RR     = 6'h00;
  localparam logic [5:0] OP_BGELTZ = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;

  // rt_field[0] under OP_BGELTZ
  localparam logic RT_BGEZ = 1'b1;
  localparam logic RT_BLTZ = 1'b0;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2A, 6'h2B: funct_legal = 1'b1;
      default:      funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [5:0] op, input logic rt0,
                                        input logic zero, input logic neg);
    case (op)
      OP_BEQ:    branch_taken = zero;
      OP_BNE:    branch_taken = !zero;
      OP_BLEZ:   branch_taken = zero | neg;
      OP_BGTZ:   branch_taken = !zero & !neg;
      OP_BGELTZ: branch_taken = (rt0 == RT_BGEZ) ? !neg : neg;
      default:   branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicyc_ctrl_fsm_mem_wdog.sv
// Memory-handshake watchdog.
//   clk, rst_n : clock, async active-low reset
//   i_wait     : a request is outstanding and not completing this cycle
//   o_expired  : this is the MEM_TIMEOUT-th consecutive waiting cycle
// MEM_TIMEOUT = 0 disables expiry.
module multicyc_mem_wdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wait,
  output logic o_expired
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Clearing on any non-waiting cycle also covers "clear on entry": every
  // entry into a memory state is preceded by a cycle with no wait pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!i_wait || o_expired)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (MEM_TIMEOUT != 0) && i_wait && (r_cnt == LAST);

endmodule

// File: rtl/multicyc_ctrl_fsm.sv
// Multicycle MIPS control unit for the shared-memory datapath.
// Inputs : clk, rst_n, opcode/funct/rt_field (from IR), alu_zero, alu_neg,
//          mem_ready (memory completes current request).
// Outputs: mem_req/mem_we/mem_addr_sel, ir_we/pc_we/reg_we strobes,
//          ALU source/op selects, writeback dst/data selects, nxt_pc_sel,
//          state (debug), sticky halted/illegal/bus_err, retired counter.
module multicyc_ctrl_fsm
  import multicyc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt_field,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             alu_srca_sel,
  output logic [2:0]       alu_srcb_sel,
  output logic [3:0]       alu_op,
  output logic [1:0]       wreg_dst_sel,
  output logic [1:0]       wreg_data_sel,
  output logic [1:0]       nxt_pc_sel,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  state_type      r_state, w_next;
  logic           r_illegal, r_bus_err;
  logic [CNT_W-1:0] r_retired;

  logic           w_mem_state, w_wait, w_expired;
  logic           w_mem_we, w_ir_we, w_pc_we, w_reg_we;
  logic           w_retire, w_set_illegal;
  mem_addr_sel_t  w_addr_sel;
  alu_srca_sel_t  w_srca;
  alu_srcb_sel_t  w_srcb;
  alu_op_t        w_alu_op;
  wreg_dst_sel_t  w_dst;
  wreg_data_sel_t w_wdata;
  nxt_pc_sel_t    w_npc;

  // Only bit 0 of rt distinguishes BGEZ/BLTZ.
  logic w_unused_rt;
  assign w_unused_rt = &{1'b0, rt_field[4:1]};

  // mem_req is kept out of the decode block so the watchdog path stays acyclic.
  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  assign w_wait      = w_mem_state && !mem_ready;

  multicyc_mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wait    (w_wait),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next        = r_state;
    w_mem_we      = 1'b0;
    w_ir_we       = 1'b0;
    w_pc_we       = 1'b0;
    w_reg_we      = 1'b0;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    w_addr_sel    = ADDR_PC;
    w_srca        = SRCA_PC;
    w_srcb        = SRCB_FOUR;
    w_alu_op      = ALU_ADD;
    w_dst         = WR_RT;
    w_wdata       = WD_ALUOUT;
    w_npc         = NPC_PLUS4;

    case (r_state)
      ST_FETCH: begin
        if (mem_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_srcb = SRCB_BEQIMM;
        case (opcode)
          OP_LW, OP_SW: w_next = ST_MEMADDR;
          OP_RR: begin
            if ((funct == FN_JR) || (funct == FN_JALR))
              w_next = ST_JMPREG;
            else if (funct_legal(funct))
              w_next = ST_RREXEC;
            else begin
              w_next        = ST_HALT;
              w_set_illegal = 1'b1;
            end
          end
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGELTZ: w_next = ST_BRANCH;
          OP_J, OP_JAL: w_next = ST_JMP;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
            w_next = ST_RIEXEC;
          OP_LUI: w_next = ST_LUI;
          default: begin
            w_next        = ST_HALT;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      ST_MEMADDR: begin
        w_srca = SRCA_RS;
        w_srcb = SRCB_IMM;
        w_next = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        w_addr_sel = ADDR_ALUOUT;
        if (mem_ready) w_next = ST_MEMWRBCK;
      end
      ST_MEMWRBCK: begin
        w_reg_we = 1'b1;
        w_dst    = WR_RT;
        w_wdata  = WD_MEMDATA;
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_MEMWR: begin
        w_addr_sel = ADDR_ALUOUT;
        w_mem_we   = 1'b1;
        if (mem_ready) begin
          w_next   = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_RREXEC: begin
        w_srca   = SRCA_RS;
        w_srcb   = SRCB_RT;
        w_alu_op = ALU_RR;
        w_next   = ST_RRWRBCK;
      end
      ST_RRWRBCK: begin
        w_reg_we = 1'b1;
        w_dst    = WR_RD;
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_RIEXEC: begin
        w_srca = SRCA_RS;
        w_srcb = SRCB_IMM;
        case (opcode)
          OP_ADDIU: w_alu_op = ALU_ADDU;
          OP_ANDI:  begin w_alu_op = ALU_AND; w_srcb = SRCB_ZEROIMM; end
          OP_ORI:   begin w_alu_op = ALU_OR;  w_srcb = SRCB_ZEROIMM; end
          OP_XORI:  begin w_alu_op = ALU_XOR; w_srcb = SRCB_ZEROIMM; end
          OP_SLTI:  w_alu_op = ALU_SLT;
          OP_SLTIU: w_alu_op = ALU_SLTU;
          default:  w_alu_op = ALU_ADD;
        endcase
        w_next = ST_RIWRBCK;
      end
      ST_RIWRBCK: begin
        w_reg_we = 1'b1;
        w_dst    = WR_RT;
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_LUI: begin
        w_reg_we = 1'b1;
        w_dst    = WR_RT;
        w_wdata  = WD_LUI;
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_BRANCH: begin
        w_srca   = SRCA_RS;
        w_srcb   = ((opcode == OP_BEQ) || (opcode == OP_BNE)) ? SRCB_RT : SRCB_ZERO;
        w_alu_op = ALU_SUB;
        w_npc    = NPC_BRANCH;
        w_pc_we  = branch_taken(opcode, rt_field[0], alu_zero, alu_neg);
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_JMP: begin
        w_pc_we = 1'b1;
        w_npc   = NPC_JMP;
        if (opcode == OP_JAL) begin
          w_reg_we = 1'b1;
          w_dst    = WR_RA31;
          w_wdata  = WD_PCLINK;
        end
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_JMPREG: begin
        w_pc_we = 1'b1;
        w_npc   = NPC_REG;
        if (funct == FN_JALR) begin
          w_reg_we = 1'b1;
          w_dst    = WR_RD;
          w_wdata  = WD_PCLINK;
        end
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_HALT;
    endcase

    if (w_expired) w_next = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_expired;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset is held.
  assign mem_req       = w_mem_state & rst_n;
  assign mem_we        = w_mem_we & rst_n;
  assign ir_we         = w_ir_we & rst_n;
  assign pc_we         = w_pc_we & rst_n;
  assign reg_we        = w_reg_we & rst_n;
  assign mem_addr_sel  = w_addr_sel;
  assign alu_srca_sel  = w_srca;
  assign alu_srcb_sel  = w_srcb;
  assign alu_op        = w_alu_op;
  assign wreg_dst_sel  = w_dst;
  assign wreg_data_sel = w_wdata;
  assign nxt_pc_sel    = w_npc;
  assign state         = r_state;
  assign halted        = (r_state == ST_HALT);
  assign illegal       = r_illegal;
  assign bus_err       = r_bus_err;
  assign retired       = r_retired;

endmodule

// File: tb/tb_multicyc_ctrl_fsm.sv
// Directed scoreboard bench for multicyc_ctrl_fsm (MEM_TIMEOUT=4, CNT_W=3).
module tb_multicyc_ctrl_fsm;
  import multicyc_ctrl_fsm_pkg::*;

  localparam int DC = -1;

  logic       clk = 1'b1;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rt_field = '0;
  logic       alu_zero = 1'b0, alu_neg = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, alu_srca_sel;
  logic [2:0] alu_srcb_sel;
  logic [3:0] alu_op, state;
  logic [1:0] wreg_dst_sel, wreg_data_sel, nxt_pc_sel;
  logic       halted, illegal, bus_err;
  logic [2:0] retired;

  multicyc_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt_field(rt_field),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel), .alu_op(alu_op),
    .wreg_dst_sel(wreg_dst_sel), .wreg_data_sel(wreg_data_sel), .nxt_pc_sel(nxt_pc_sel),
    .state(state), .halted(halted), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int st, strb, asel, srca, srcb, alu, dst, wd, npc, ret, flags;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [2:0] exp_ret = '0;
  logic [2:0] exp_flags = '0;   // {halted, illegal, bus_err}

  // {opcode, rt0, zero, neg, taken}
  logic [9:0] br_tab [12] = '{
    {OP_BNE,    4'b0001}, {OP_BNE,    4'b0100},
    {OP_BGELTZ, 4'b1001}, {OP_BGELTZ, 4'b1010},
    {OP_BGELTZ, 4'b0011}, {OP_BGELTZ, 4'b0000},
    {OP_BEQ,    4'b0101}, {OP_BEQ,    4'b0000},
    {OP_BLEZ,   4'b0011}, {OP_BLEZ,   4'b0000},
    {OP_BGTZ,   4'b0001}, {OP_BGTZ,   4'b0100}
  };
  logic [5:0] ri_op   [4] = '{OP_ORI, OP_ADDI, OP_SLTIU, OP_XORI};
  int         ri_srcb [4] = '{SRCB_ZEROIMM, SRCB_IMM, SRCB_IMM, SRCB_ZEROIMM};
  int         ri_alu  [4] = '{ALU_OR, ALU_ADD, ALU_SLTU, ALU_XOR};

  task automatic chk(input string tag, input string name, input int act, input int exp);
    if (exp != DC) begin
      n_cmp++;
      if (act != exp) begin
        n_bad++;
        $display("FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
      end
    end
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "state",     int'(state), e.st);
        chk(e.tag, "strobes",   int'({mem_req, mem_we, ir_we, pc_we, reg_we}), e.strb);
        chk(e.tag, "addr_sel",  int'(mem_addr_sel), e.asel);
        chk(e.tag, "srca",      int'(alu_srca_sel), e.srca);
        chk(e.tag, "srcb",      int'(alu_srcb_sel), e.srcb);
        chk(e.tag, "alu_op",    int'(alu_op), e.alu);
        chk(e.tag, "wreg_dst",  int'(wreg_dst_sel), e.dst);
        chk(e.tag, "wreg_data", int'(wreg_data_sel), e.wd);
        chk(e.tag, "nxt_pc",    int'(nxt_pc_sel), e.npc);
        chk(e.tag, "retired",   int'(retired), e.ret);
        chk(e.tag, "flags",     int'({halted, illegal, bus_err}), e.flags);
      end
    end
  end

  task automatic cyc(input string tag, input int st, input int strb, input logic mr,
                     input int asel, srca, srcb, alu, dst, wd, npc, input bit done);
    exp_t e;
    mem_ready = mr;
    e.tag = tag; e.st = st; e.strb = strb; e.asel = asel; e.srca = srca;
    e.srcb = srcb; e.alu = alu; e.dst = dst; e.wd = wd; e.npc = npc;
    e.ret = int'(exp_ret); e.flags = int'(exp_flags);
    q.push_back(e);
    @(posedge clk); #1;
    if (done) exp_ret++;
  endtask

  task automatic t_ins(input logic [5:0] op, input logic [5:0] fn, input logic rt0,
                       input logic z, input logic n);
    opcode = op; funct = fn; rt_field = {4'b0, rt0}; alu_zero = z; alu_neg = n;
  endtask

  task automatic t_fetch(input string tag, input logic mr);
    cyc({tag, ".F"}, ST_FETCH, mr ? 5'b10110 : 5'b10000, mr,
        ADDR_PC, SRCA_PC, SRCB_FOUR, ALU_ADD, DC, DC, NPC_PLUS4, 1'b0);
  endtask

  // mem_ready high here: must be ignored while mem_req=0
  task automatic t_decode(input string tag);
    cyc({tag, ".D"}, ST_DECODE, 0, 1'b1, DC, SRCA_PC, SRCB_BEQIMM, ALU_ADD, DC, DC, DC, 1'b0);
  endtask

  task automatic t_rst(input string tag);
    rst_n = 1'b0;
    exp_ret = '0;
    exp_flags = '0;
    cyc(tag, ST_FETCH, 0, 1'b0, DC, DC, DC, DC, DC, DC, DC, 1'b0);
  endtask

  initial begin
    logic [5:0] bop;
    logic brt, bz, bn, btk;
    string tg;

    #1;
    t_rst("RST0");
    t_rst("RST1");
    rst_n = 1'b1;

    // LW, 2 wait cycles on the data read: 7 cycles
    t_ins(OP_LW, 6'h0, 1'b0, 1'b0, 1'b0);
    t_fetch("LW", 1'b1);
    t_decode("LW");
    cyc("LW.MA", ST_MEMADDR, 0, 1'b0, DC, SRCA_RS, SRCB_IMM, ALU_ADD, DC, DC, DC, 1'b0);
    cyc("LW.RD0", ST_MEMRD, 5'b10000, 1'b0, ADDR_ALUOUT, DC, DC, DC, DC, DC, DC, 1'b0);
    cyc("LW.RD1", ST_MEMRD, 5'b10000, 1'b0, ADDR_ALUOUT, DC, DC, DC, DC, DC, DC, 1'b0);
    cyc("LW.RD2", ST_MEMRD, 5'b10000, 1'b1, ADDR_ALUOUT, DC, DC, DC, DC, DC, DC, 1'b0);
    cyc("LW.WB", ST_MEMWRBCK, 5'b00001, 1'b0, DC, DC, DC, DC, WR_RT, WD_MEMDATA, DC, 1'b1);

    // Branch set
    for (int unsigned i = 0; i < 12; i++) begin
      {bop, brt, bz, bn, btk} = br_tab[i];
      tg = $sformatf("BR%0d", i);
      t_ins(bop, 6'h0, brt, bz, bn);
      t_fetch(tg, 1'b1);
      t_decode(tg);
      cyc({tg, ".B"}, ST_BRANCH, btk ? 5'b00010 : 5'b00000, 1'b0, DC, SRCA_RS,
          ((bop == OP_BEQ) || (bop == OP_BNE)) ? SRCB_RT : SRCB_ZERO,
          ALU_SUB, DC, DC, NPC_BRANCH, 1'b1);
    end

    // Jumps
    t_ins(OP_JAL, 6'h0, 1'b0, 1'b0, 1'b0);
    t_fetch("JAL", 1'b1); t_decode("JAL");
    cyc("JAL.J", ST_JMP, 5'b00011, 1'b0, DC, DC, DC, DC, WR_RA31, WD_PCLINK, NPC_JMP, 1'b1);
    t_ins(OP_J, 6'h0, 1'b0, 1'b0, 1'b0);
    t_fetch("J", 1'b1); t_decode("J");
    cyc("J.J", ST_JMP, 5'b00010, 1'b0, DC, DC, DC, DC, DC, DC, NPC_JMP, 1'b1);
    t_ins(OP_RR, FN_JALR, 1'b0, 1'b0, 1'b0);
    t_fetch("JALR", 1'b1); t_decode("JALR");
    cyc("JALR.JR", ST_JMPREG, 5'b00011, 1'b0, DC, DC, DC, DC, WR_RD, WD_PCLINK, NPC_REG, 1'b1);
    t_ins(OP_RR, FN_JR, 1'b0, 1'b0, 1'b0);
    t_fetch("JR", 1'b1); t_decode("JR");
    cyc("JR.JR", ST_JMPREG, 5'b00010, 1'b0, DC, DC, DC, DC, DC, DC, NPC_REG, 1'b1);

    // Register-immediate
    for (int unsigned i = 0; i < 4; i++) begin
      tg = $sformatf("RI%0d", i);
      t_ins(ri_op[i], 6'h0, 1'b0, 1'b0, 1'b0);
      t_fetch(tg, 1'b1);
      t_decode(tg);
      cyc({tg, ".X"}, ST_RIEXEC, 0, 1'b0, DC, SRCA_RS, ri_srcb[i], ri_alu[i], DC, DC, DC, 1'b0);
      cyc({tg, ".W"}, ST_RIWRBCK, 5'b00001, 1'b0, DC, DC, DC, DC, WR_RT, WD_ALUOUT, DC, 1'b1);
    end

    // SW with one fetch wait cycle
    t_ins(OP_SW, 6'h0, 1'b0, 1'b0, 1'b0);
    t_fetch("SW0", 1'b0);
    t_fetch("SW1", 1'b1);
    t_decode("SW");
    cyc("SW.MA", ST_MEMADDR, 0, 1'b0, DC, SRCA_RS, SRCB_IMM, ALU_ADD, DC, DC, DC, 1'b0);
    cyc("SW.WR", ST_MEMWR, 5'b11000, 1'b1, ADDR_ALUOUT, DC, DC, DC, DC, DC, DC, 1'b1);

    // R-type ADD and LUI
    t_ins(OP_RR, FN_ADD, 1'b0, 1'b0, 1'b0);
    t_fetch("ADD", 1'b1); t_decode("ADD");
    cyc("ADD.X", ST_RREXEC, 0, 1'b0, DC, SRCA_RS, SRCB_RT, ALU_RR, DC, DC, DC, 1'b0);
    cyc("ADD.W", ST_RRWRBCK, 5'b00001, 1'b0, DC, DC, DC, DC, WR_RD, WD_ALUOUT, DC, 1'b1);
    t_ins(OP_LUI, 6'h0, 1'b0, 1'b0, 1'b0);
    t_fetch("LUI", 1'b1); t_decode("LUI");
    cyc("LUI.L", ST_LUI, 5'b00001, 1'b0, DC, DC, DC, DC, WR_RT, WD_LUI, DC, 1'b1);

    // Illegal opcode: sticky halt, memory ignored
    t_ins(6'h3F, 6'h0, 1'b0, 1'b0, 1'b0);
    t_fetch("ILL", 1'b1); t_decode("ILL");
    exp_flags = 3'b110;
    for (int unsigned i = 0; i < 3; i++)
      cyc($sformatf("ILL.H%0d", i), ST_HALT, 0, 1'b1, DC, DC, DC, DC, DC, DC, DC, 1'b0);
    t_rst("RST2");
    rst_n = 1'b1;

    // Illegal funct
    t_ins(OP_RR, 6'h3F, 1'b0, 1'b0, 1'b0);
    t_fetch("ILF", 1'b1); t_decode("ILF");
    exp_flags = 3'b110;
    cyc("ILF.H", ST_HALT, 0, 1'b1, DC, DC, DC, DC, DC, DC, DC, 1'b0);
    t_rst("RST3");
    rst_n = 1'b1;

    // Reset in the middle of an R-type: no writeback in the abort cycle
    t_ins(OP_RR, FN_ADD, 1'b0, 1'b0, 1'b0);
    t_fetch("AB", 1'b1); t_decode("AB");
    cyc("AB.X", ST_RREXEC, 0, 1'b0, DC, SRCA_RS, SRCB_RT, ALU_RR, DC, DC, DC, 1'b0);
    t_rst("ABORT");
    rst_n = 1'b1;

    // Watchdog: 4 waiting fetch cycles then Halt with bus_err
    t_ins(OP_LW, 6'h0, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++)
      t_fetch($sformatf("WD%0d", i), 1'b0);
    exp_flags = 3'b101;
    cyc("WD.H0", ST_HALT, 0, 1'b1, DC, DC, DC, DC, DC, DC, DC, 1'b0);
    cyc("WD.H1", ST_HALT, 0, 1'b1, DC, DC, DC, DC, DC, DC, DC, 1'b0);
    t_rst("RST4");
    rst_n = 1'b1;
    t_fetch("POST", 1'b1);
    t_decode("POST");

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
